// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, buffer state encoding and the
// FIPS-197 reference key schedule used by benches.
package aes_pkg;

  localparam int AES_KEY_BYTES = 16;
  localparam int AES128_ROUNDS = 10;

  localparam logic [1:0] ENC_EMPTY = 2'd0;
  localparam logic [1:0] ENC_FILL  = 2'd1;
  localparam logic [1:0] ENC_READY = 2'd2;
  localparam logic [1:0] ENC_READ  = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = ENC_EMPTY,
    ST_FILL  = ENC_FILL,
    ST_READY = ENC_READY,
    ST_READ  = ENC_READ
  } rkb_state_t;

  // FIPS-197 Appendix A.1 cipher key and its full expanded schedule.
  localparam logic [127:0] FIPS197_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  localparam logic [127:0] FIPS197_RK [AES128_ROUNDS+1] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

endpackage

// File: rtl/key_ram_176x8.sv
// Round-key storage: one write port and one synchronous read port whose
// output register doubles as the replay byte seen by the datapath.
module key_ram_176x8
  import aes_pkg::*;
#(
  parameter int DEPTH = (AES128_ROUNDS + 1) * AES_KEY_BYTES,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Array write; contents survive reset, only the schedule-valid flag is cleared upstream.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // One-cycle read; output holds its value when no read is issued and clears on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/round_key_buffer.sv
// Captures the byte-serial AES-128 round-key stream and replays any one
// round key, MSB byte first, on request from the encryption datapath.
module round_key_buffer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int KEY_BYTES  = AES_KEY_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kin_start,
  input  logic       kin_valid,
  input  logic [7:0] kin_byte,
  output logic       key_ready,
  input  logic       rd_req,
  input  logic [3:0] rd_round,
  output logic       rd_valid,
  output logic [7:0] rd_byte,
  output logic       rd_last,
  output logic       rd_err
);

  localparam int DEPTH = (NUM_ROUNDS + 1) * KEY_BYTES;
  localparam int CW    = $clog2(KEY_BYTES);
  localparam logic [7:0]    LAST_ADDR = 8'(DEPTH - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(KEY_BYTES - 2);

  rkb_state_t    state, state_n;
  logic [7:0]    wr_ptr, wr_ptr_n;
  logic [7:0]    rd_base, rd_base_n;
  logic [CW-1:0] rd_cnt, rd_cnt_n;
  logic          key_ready_n, rd_valid_n, rd_last_n, rd_err_n;

  logic          ram_we, ram_re;
  logic [7:0]    ram_waddr, ram_raddr;

  logic          round_ok;
  logic [7:0]    round_base;

  assign round_ok   = (rd_round <= 4'(NUM_ROUNDS));
  assign round_base = 8'(rd_round) * 8'(KEY_BYTES);

  // rd_cnt is the byte index currently presented on rd_byte; the RAM is
  // always fetching the next one so the replay streams without bubbles.
  // Next-state, write/read addressing and output decode; kin_start overrides everything.
  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    rd_base_n   = rd_base;
    rd_cnt_n    = rd_cnt;
    key_ready_n = key_ready;
    rd_valid_n  = 1'b0;
    rd_last_n   = 1'b0;
    rd_err_n    = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr;
    ram_re      = 1'b0;
    ram_raddr   = rd_base + 8'(rd_cnt) + 8'd1;

    if (kin_start) begin
      state_n     = ST_FILL;
      key_ready_n = 1'b0;
      rd_cnt_n    = '0;
      rd_err_n    = rd_req;
      if (kin_valid) begin
        ram_we    = 1'b1;
        ram_waddr = '0;
        wr_ptr_n  = 8'd1;
      end else begin
        wr_ptr_n  = '0;
      end
    end else begin
      unique case (state)
        ST_EMPTY: begin
          rd_err_n = rd_req;
        end
        ST_FILL: begin
          rd_err_n = rd_req;
          if (kin_valid) begin
            ram_we   = 1'b1;
            wr_ptr_n = wr_ptr + 8'd1;
            if (wr_ptr == LAST_ADDR) begin
              state_n     = ST_READY;
              key_ready_n = 1'b1;
            end
          end
        end
        ST_READY: begin
          if (rd_req) begin
            if (round_ok) begin
              state_n    = ST_READ;
              rd_base_n  = round_base;
              rd_cnt_n   = '0;
              ram_re     = 1'b1;
              ram_raddr  = round_base;
              rd_valid_n = 1'b1;
            end else begin
              rd_err_n   = 1'b1;
            end
          end
        end
        ST_READ: begin
          rd_err_n   = rd_req;
          ram_re     = 1'b1;
          rd_valid_n = 1'b1;
          rd_cnt_n   = rd_cnt + 1'b1;
          if (rd_cnt == PRE_LAST) begin
            rd_last_n = 1'b1;
            state_n   = ST_READY;
          end
        end
        default: begin
          state_n = ST_EMPTY;
        end
      endcase
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      wr_ptr    <= '0;
      rd_base   <= '0;
      rd_cnt    <= '0;
      key_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_base   <= rd_base_n;
      rd_cnt    <= rd_cnt_n;
      key_ready <= key_ready_n;
      rd_valid  <= rd_valid_n;
      rd_last   <= rd_last_n;
      rd_err    <= rd_err_n;
    end
  end

  key_ram_176x8 #(
    .DEPTH (DEPTH),
    .AW    (8)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (kin_byte),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rd_byte)
  );

endmodule

// File: tb/tb_round_key_buffer.sv
// Self-checking bench for round_key_buffer: randomized fills and reads
// compared cycle by cycle against a queue-based behavioural model.
module tb_round_key_buffer;
  import aes_pkg::*;

  localparam int NR    = AES128_ROUNDS;
  localparam int KB    = AES_KEY_BYTES;
  localparam int TOTAL = (NR + 1) * KB;

  logic       clk = 1'b0;
  logic       rst;
  logic       kin_start, kin_valid;
  logic [7:0] kin_byte;
  logic       key_ready;
  logic       rd_req;
  logic [3:0] rd_round;
  logic       rd_valid, rd_last, rd_err;
  logic [7:0] rd_byte;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [TOTAL];
  int         fill_cnt;
  bit         model_ready, model_filling;
  logic [7:0] replay_q [$];
  bit         exp_valid, exp_last, exp_err;
  logic [7:0] exp_byte;

  logic [7:0] cap_q [$];
  logic [7:0] fips_sched [TOTAL];
  logic [7:0] new_sched [TOTAL];

  // Free-running clock.
  always #5 clk = ~clk;

  round_key_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .kin_start (kin_start),
    .kin_valid (kin_valid),
    .kin_byte  (kin_byte),
    .key_ready (key_ready),
    .rd_req    (rd_req),
    .rd_round  (rd_round),
    .rd_valid  (rd_valid),
    .rd_byte   (rd_byte),
    .rd_last   (rd_last),
    .rd_err    (rd_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; the model decides what should appear after the edge.
  task automatic applyStimulus(input bit r_n, input bit st, input bit kv, input logic [7:0] kb,
                               input bit rq, input logic [3:0] rr);
    rst       = r_n;
    kin_start = st;
    kin_valid = kv;
    kin_byte  = kb;
    rd_req    = rq;
    rd_round  = rr;
    exp_err   = 1'b0;
    if (!r_n) begin
      model_ready   = 1'b0;
      model_filling = 1'b0;
      fill_cnt      = 0;
      replay_q.delete();
      exp_valid     = 1'b0;
      exp_last      = 1'b0;
    end else if (st) begin
      exp_err       = rq;
      model_ready   = 1'b0;
      model_filling = 1'b1;
      fill_cnt      = 0;
      replay_q.delete();
      if (kv) begin
        model_mem[0] = kb;
        fill_cnt     = 1;
      end
      exp_valid = 1'b0;
      exp_last  = 1'b0;
    end else begin
      if (rq) begin
        if (model_ready && int'(rr) <= NR && replay_q.size() == 0) begin
          for (int i = 0; i < KB; i++) replay_q.push_back(model_mem[int'(rr) * KB + i]);
        end else begin
          exp_err = 1'b1;
        end
      end
      if (model_filling && kv) begin
        model_mem[fill_cnt] = kb;
        fill_cnt++;
        if (fill_cnt == TOTAL) begin
          model_ready   = 1'b1;
          model_filling = 1'b0;
        end
      end
      if (replay_q.size() > 0) begin
        exp_byte  = replay_q.pop_front();
        exp_valid = 1'b1;
        exp_last  = (replay_q.size() == 0);
      end else begin
        exp_valid = 1'b0;
        exp_last  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("key_ready", key_ready, model_ready);
    checkOutput("rd_valid", rd_valid, exp_valid);
    checkOutput("rd_last", rd_last, exp_last);
    checkOutput("rd_err", rd_err, exp_err);
    if (!r_n) checkOutput("rd_byte_reset", rd_byte, 8'h00);
    else if (exp_valid) checkOutput("rd_byte", rd_byte, exp_byte);
    if (rd_valid) cap_q.push_back(rd_byte);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
  endtask

  task automatic start_read(input logic [3:0] r);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, r);
  endtask

  // gap_mode: 0 continuous, 1 alternating valid/idle, 2 random idle gaps.
  task automatic fill_key(input bit use_fips, input int gap_mode);
    logic [7:0] b;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    checkOutput("start_clears_ready", key_ready, 1'b0);
    checkOutput("start_clears_valid", rd_valid, 1'b0);
    for (int i = 0; i < TOTAL; i++) begin
      if (gap_mode == 1 && i > 0) idle(1);
      if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, 4'd0);
      end
      b = use_fips ? fips_sched[i] : new_sched[i];
      applyStimulus(1'b1, 1'b0, 1'b1, b, (i == 50), 4'($urandom_range(0, NR)));
    end
    checkOutput("key_ready_after_fill", key_ready, 1'b1);
  endtask

  task automatic check_capture(input string tag, input int offset, input bit use_fips, input int r);
    logic [7:0] want;
    for (int i = 0; i < KB; i++) begin
      want = use_fips ? fips_sched[r * KB + i] : new_sched[r * KB + i];
      checkOutput($sformatf("%s_b%0d", tag, i), cap_q[offset + i], want);
    end
  endtask

  initial begin
    logic [127:0] rk;
    logic [3:0]   r;

    rst = 1'b0; kin_start = 1'b0; kin_valid = 1'b0; kin_byte = 8'h00;
    rd_req = 1'b0; rd_round = 4'd0;
    for (int k = 0; k <= NR; k++) begin
      rk = FIPS197_RK[k];
      for (int i = 0; i < KB; i++) fips_sched[k * KB + i] = rk[127 - 8 * i -: 8];
    end
    for (int i = 0; i < TOTAL; i++) new_sched[i] = 8'($urandom);

    // Reset, stray bytes and reads while empty.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    idle(2);

    // FIPS-197 continuous fill, then round 0 replay.
    fill_key(1'b1, 0);
    cap_q.delete();
    start_read(4'd0);
    idle(16);
    checkOutput("r0_count", cap_q.size(), KB);
    check_capture("fips_r0", 0, 1'b1, 0);

    // Round 1 then round 10 requested on the rd_last cycle.
    cap_q.delete();
    start_read(4'd1);
    idle(15);
    checkOutput("b2b_last_seen", rd_last, 1'b1);
    start_read(4'd10);
    idle(15);
    checkOutput("b2b_count", cap_q.size(), 2 * KB);
    check_capture("fips_r1", 0, 1'b1, 1);
    check_capture("fips_r10", KB, 1'b1, 10);
    idle(2);

    // Illegal round numbers and a request in the middle of a replay.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd11);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd15);
    idle(1);
    cap_q.delete();
    start_read(4'd3);
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd2);
    idle(12);
    checkOutput("midread_count", cap_q.size(), KB);
    check_capture("fips_r3", 0, 1'b1, 3);

    // Random reads, occasionally back to back.
    repeat (6) begin
      r = 4'($urandom_range(0, NR));
      cap_q.delete();
      start_read(r);
      idle(15);
      idle($urandom_range(1, 3));
      check_capture("rand_rd", 0, 1'b1, int'(r));
    end

    // kin_start at the 5th byte of a replay, gapped FIPS refill, round 10.
    start_read(4'd7);
    idle(4);
    fill_key(1'b1, 1);
    cap_q.delete();
    start_read(4'd10);
    idle(16);
    check_capture("gap_r10", 0, 1'b1, 10);

    // Abort again and refill with a random schedule.
    start_read(4'd4);
    idle(4);
    fill_key(1'b0, 2);
    cap_q.delete();
    start_read(4'd0);
    idle(16);
    check_capture("new_r0", 0, 1'b0, 0);

    // Reset in the middle of a fill.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0, 1'b1, fips_sched[i], 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 4'd0);
    checkOutput("rst_fill_ready", key_ready, 1'b0);
    checkOutput("rst_fill_byte", rd_byte, 8'h00);
    repeat (80) applyStimulus(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 4'd0);
    checkOutput("rst_ignores_bytes", key_ready, 1'b0);
    fill_key(1'b1, 0);
    cap_q.delete();
    start_read(4'd5);
    idle(16);
    check_capture("refill_r5", 0, 1'b1, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_key_buffer.md
Name: round_key_buffer

Overview:
- Downstream of the 8-bit key-expansion controller.
- Captures the byte-serial round-key stream for all 11 AES-128 round keys (round 0 = cipher key, rounds 1..10), 176 bytes in total.
- Replays any one selected round key byte-serially, MSB byte first, to the encryption datapath on request.
- Decouples key-schedule timing from encryption round timing, so the datapath no longer depends on free-running cycle counters.

Parameters:
- NUM_ROUNDS, 10, number of expanded round keys after round 0. Total keys stored = NUM_ROUNDS+1.
- KEY_BYTES, 16, bytes per round key.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset; 0 = reset, sampled on posedge clk.
- kin_start  input  1  one-cycle pulse: a new key schedule begins; discards the stored schedule.
- kin_valid  input  1  kin_byte is valid this cycle.
- kin_byte  input  8  round-key byte stream, round 0 byte 0 (bits 127:120) first.
- key_ready  output  1  all (NUM_ROUNDS+1)*KEY_BYTES bytes captured.
- rd_req  input  1  one-cycle read request.
- rd_round  input  4  round key index, 0..NUM_ROUNDS, sampled with rd_req.
- rd_valid  output  1  rd_byte is valid.
- rd_byte  output  8  replayed key byte, MSB byte first.
- rd_last  output  1  high with the 16th byte of a replay.
- rd_err  output  1  one-cycle pulse: request rejected.

Behaviour:
- Reset (rst=0 at posedge): state=EMPTY, wr_ptr=0, rd_cnt=0. Outputs key_ready=0, rd_valid=0, rd_byte=0, rd_last=0, rd_err=0. Storage contents are not reset.
- Storage: (NUM_ROUNDS+1)*KEY_BYTES x 8 array. Address = round*KEY_BYTES + byte_index. wr_ptr is 8 bits wide.
- States: EMPTY, FILL, READY, READ.
- EMPTY:
  - kin_start -> FILL, wr_ptr=0.
  - kin_valid without a prior kin_start is ignored.
- FILL:
  - Each kin_valid writes kin_byte at wr_ptr, then wr_ptr++.
  - When the write at wr_ptr=175 occurs -> READY; key_ready=1 the following cycle. Any kin_valid after that is ignored until the next kin_start.
- kin_start in any state:
  - key_ready=0 next cycle; state -> FILL, wr_ptr=0.
  - If kin_valid is high in the same cycle, that byte is written at address 0 and wr_ptr becomes 1.
  - Aborts an in-progress READ: rd_valid=0 and rd_last=0 from the next cycle; no rd_err.
- READY:
  - rd_req with rd_round<=NUM_ROUNDS -> READ; rd_cnt=0.
  - First byte appears the cycle after rd_req (latency 1): rd_valid=1 for exactly 16 consecutive cycles, bytes at addresses round*16+0..15, rd_last=1 on the 16th byte.
  - State returns to READY after the 16th byte.
- Back-to-back reads: rd_req in the same cycle as rd_last=1 is accepted. The next replay starts on the following cycle with no gap.
- rd_req during READ other than on the rd_last cycle -> rd_err pulse next cycle; the current replay continues unaffected.
- rd_req in EMPTY or FILL, or with rd_round>NUM_ROUNDS -> rd_err=1 for one cycle; no read; state unchanged.
- rd_byte holds its last value when rd_valid=0. Benches must check it only when rd_valid=1.
- Reset mid-FILL or mid-READ: immediately returns to reset values; the partial schedule is invalid (key_ready=0).
- Simultaneous rd_req and kin_start: kin_start wins; rd_req is rejected with rd_err.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_KEY_BYTES=16, AES128_ROUNDS=10;
  - state encoding localparams for EMPTY/FILL/READY/READ;
  - FIPS-197 test key constants for benches.
- One natural sub-module: key_ram_176x8, a single write port plus a single synchronous read port (1-cycle read). Inferred as distributed/block RAM. The round_key_buffer FSM drives its addresses.

Test Plan:
- Reset, then fill with FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c schedule (176 bytes, kin_valid continuous) -> key_ready=1 exactly 1 cycle after the 176th write; rd_req rd_round=0 -> 16 bytes 2b,7e,...,3c starting 1 cycle later, rd_last on 3c.
- rd_round=1, then rd_round=10 issued on the rd_last cycle -> 32 contiguous rd_valid cycles: a0fafe17...2a6c7605 then d014f9a8...b6630ca6, no gap.
- Gapped fill (kin_valid toggling 1,0,1,...) -> key_ready after 176 valid bytes only; round 10 readback matches d014f9a8c9ee2589e13f0cc8b6630ca6.
- Errors: rd_req during FILL, rd_req with rd_round=11, rd_req mid-READ -> a single rd_err pulse each; the ongoing replay is not disturbed.
- kin_start at the 5th byte of a READ -> rd_valid=0 next cycle; key_ready=0; refill with a new key, then round 0 readback returns the new key.
- rst=0 asserted mid-FILL at wr_ptr=100 -> all outputs 0 next cycle; kin_valid bytes ignored until kin_start; a full refill then produces key_ready=1.
